data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Load/store responder for the RV32I core's data side. It receives the ALU result as the address, writeData as the store data and funct3 as the access size. It returns readData to the datapath's result mux.
- Word-organised RAM, internal to the block.
- Req/ready handshake: one access in flight at a time.
- Byte/halfword lane steering and sign/zero extension.
- Flags misaligned and unsupported accesses.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the RAM; must be a power of two.
IDX_W, 8, log2(DEPTH_WORDS); word index taken from addr[IDX_W+1:2].

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req  in  1  access request; sampled only in IDLE.
we  in  1  1 = store, 0 = load; sampled with req.
addr  in  32  byte address (aluRes); bits above IDX_W+1 ignored, so addresses wrap modulo 4*DEPTH_WORDS.
wdata  in  32  store data (writeData); the low byte/half is used for SB/SH.
f3  in  3  funct3 size/sign code.
rdata  out  32  load result, extended to 32 bits.
ready  out  1  one-cycle completion pulse.
err  out  1  valid with ready; 1 = misaligned or unsupported f3.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= IDLE; rdata=0, ready=0, err=0.
  - RAM contents are not cleared.
  - rst has priority over req: no access is accepted and no write occurs on a reset edge.
  - Reset while in ACCESS drops the pending ready pulse; the write of an already-accepted store has already happened.
- States: IDLE, ACCESS.
  - IDLE & req=1 at edge N:
    - Accept the request; capture addr, we, f3 into internal registers; go to ACCESS.
    - For a legal store, the RAM byte lanes are written at edge N with wdata.
  - ACCESS at edge N+1 (unconditional):
    - Drive ready=1, err and rdata for the cycle after edge N+1; return to IDLE.
  - Latency: ready is high in the cycle after the acceptance cycle, which is exactly 2 edges after req was first seen high in IDLE.
  - Throughput: one access per 2 cycles. req held high through the ready cycle is re-accepted at the edge that ends the ready cycle; it is treated as a new access.
  - ready is a single-cycle pulse; it is low in all other cycles.
- Inputs changing after acceptance have no effect.
- f3 decode:
  - 000 = byte, sign-extended.
  - 001 = half, sign-extended.
  - 010 = word.
  - 100 = byte, zero-extended.
  - 101 = half, zero-extended.
  - 011, 110, 111 = unsupported.
  - For stores, 100/101 are unsupported (err=1, no write).
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=00.
  - On a misaligned or unsupported access: no RAM write, rdata=0, ready=1, err=1.
- Lane steering (little-endian):
  - Byte at lane addr[1:0]; half at lane addr[1] (bits 15:0 or 31:16).
  - Store writes only the addressed lanes; other bytes of the word are preserved.
  - Load reads the whole word, selects the lane, and extends per f3.
- rdata:
  - Holds its value between accesses.
  - After a store, rdata=0.
- The RAM read is synchronous, so the block maps to block RAM.

Test Plan:
1. Apply rst for 2 cycles → rdata=0, ready=0, err=0. Then SW addr=0x10, wdata=0xDEADBEEF, followed by LW 0x10 → ready 2 edges after req; rdata=0xDEADBEEF, err=0.
2. Word at 0x20 = 0x11223344. SB addr=0x22, wdata=0x000000AB. Then LW 0x20 → 0x11AB3344. Then LB 0x22 → 0xFFFFFFAB. Then LBU 0x22 → 0x000000AB.
3. SH addr=0x32, wdata=0x8001. Then LH 0x32 → 0xFFFF8001; LHU 0x32 → 0x00008001; LW 0x30 has bits 31:16 = 0x8001.
4. LW 0x41 → err=1, rdata=0. SH 0x43 → err=1, and a following LW 0x40 shows the word unchanged. Load with f3=011 → err=1. Store with f3=100 → err=1, no write.
5. Hold req=1 with alternating SW/LW to consecutive addresses → ready pulses every 2nd cycle; each load returns the preceding store's data.
6. Accept LW, then assert rst in the ACCESS cycle → no ready pulse, state IDLE. Store accepted and then reset → data persists and is read back after reset. Address 0x10 + 4*DEPTH_WORDS aliases to 0x10.

Source files
------------

// File: rtl/data_mem_if.sv
// Load/store request bus between the datapath and the data memory controller.
// The datapath side is the master; the controller answers on the slave side.
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  f3;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, f3, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, f3, output rdata, ready, err);
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data-side load/store responder: word RAM with byte lanes, one access in
// flight, lane steering, sign/zero extension and misaligned/unsupported flagging.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]       state_reg;
  logic [1:0]       lo_reg;
  logic             we_reg;
  logic [2:0]       f3_reg;
  logic             bad_reg;
  logic [31:0]      rdata_reg;
  logic             ready_reg;
  logic             err_reg;

  logic             accept;
  logic             bad_next;
  logic [3:0]       be_next;
  logic [31:0]      wlane_next;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_val;
  logic             unused_addr_bits;

  // Reset wins over a request: nothing is accepted and nothing is written.
  assign accept           = (state_reg == IDLE) && bus.req && !rst;
  assign idx              = bus.addr[IDX_W+1:2];
  assign unused_addr_bits = ^bus.addr[31:IDX_W+2];

  always_comb begin
    bad_next   = 1'b1;
    be_next    = 4'b0000;
    wlane_next = bus.wdata;
    case (bus.f3)
      3'b000, 3'b100: begin
        bad_next   = bus.we && bus.f3[2];
        be_next    = 4'b0001 << bus.addr[1:0];
        wlane_next = {4{bus.wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        bad_next   = bus.addr[0] || (bus.we && bus.f3[2]);
        be_next    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wlane_next = {2{bus.wdata[15:0]}};
      end
      3'b010: begin
        bad_next = (bus.addr[1:0] != 2'b00);
        be_next  = 4'b1111;
      end
      default: bad_next = 1'b1;
    endcase
  end

  // One independent byte-wide RAM per lane keeps byte writes and the registered
  // read mappable onto block RAM without read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (accept && bus.we && !bad_next && be_next[gi])
          mem[idx] <= wlane_next[gi*8 +: 8];
        if (accept)
          rd_byte_reg <= mem[idx];
      end

      assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  always_comb begin
    load_byte = rd_word[8*lo_reg +: 8];
    load_half = lo_reg[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_reg[1:0])
      2'b00:   load_val = {{24{load_byte[7] & ~f3_reg[2]}}, load_byte};
      2'b01:   load_val = {{16{load_half[15] & ~f3_reg[2]}}, load_half};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          if (bus.req) begin
            lo_reg    <= bus.addr[1:0];
            we_reg    <= bus.we;
            f3_reg    <= bus.f3;
            bad_reg   <= bad_next;
            state_reg <= ACCESS;
          end
        end
        default: begin
          ready_reg <= 1'b1;
          err_reg   <= bad_reg;
          rdata_reg <= (bad_reg || we_reg) ? 32'd0 : load_val;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdata = rdata_reg;
  assign bus.ready = ready_reg;
  assign bus.err   = err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random traffic
// compared against a byte-addressed memory model.
module tb_data_mem_ctrl;

  localparam int DEPTH     = 256;
  localparam int MEM_BYTES = 4 * DEPTH;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [7:0] mdl [MEM_BYTES];

  data_mem_if bus ();

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .IDX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte-addressed little-endian memory with wrap-around.
  function automatic void mdl_access(input logic w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [2:0] f,
                                     output logic [31:0] rd, output logic e);
    int n;
    bit sgn;
    int ba;
    logic [63:0] val;
    n = 0;
    sgn = 1'b0;
    case (f)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: n = 0;
    endcase
    if (w && (f == 3'd4 || f == 3'd5)) n = 0;
    ba = int'(a % 32'(MEM_BYTES));
    e  = (n == 0) || (ba % n != 0);
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[ba + i] = d[8*i +: 8];
      end else begin
        val = 64'd0;
        for (int i = 0; i < n; i++) val = val | (64'(mdl[ba + i]) << (8 * i));
        if (sgn && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
        rd = val[31:0];
      end
    end
  endfunction

  // Issues one request and returns the result seen on the ready pulse plus the
  // number of edges from the accepting edge to the one that raised ready.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f, output logic [31:0] rd,
                           output logic e, output int lat);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.f3 = f;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    bus.we = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom; bus.f3 = 3'($urandom);
    lat = 1;
    while (!bus.ready && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rd = bus.rdata;
    e  = bus.err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'd0); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    $display("reset: rdata=%h ready=%b err=%b", bus.rdata, bus.ready, bus.err);
  endtask

  task automatic test_word;
    logic [31:0] rd, exp_rd; logic e, exp_e; int lat;
    mdl_access(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, exp_rd, exp_e);
    do_access(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL sw_result got=%h/%b exp=0/0", rd, e); end
    do_access(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_word got=%h/%b exp=deadbeef/0", rd, e); end
    $display("word: LW 0x10 -> %h err=%b lat=%0d", rd, e, lat);
  endtask

  task automatic test_byte;
    logic [31:0] rd, exp_rd; logic e, exp_e; int lat;
    mdl_access(1'b1, 32'h20, 32'h11223344, 3'd2, exp_rd, exp_e);
    do_access(1'b1, 32'h20, 32'h11223344, 3'd2, rd, e, lat);
    mdl_access(1'b1, 32'h22, 32'h000000AB, 3'd0, exp_rd, exp_e);
    do_access(1'b1, 32'h22, 32'h000000AB, 3'd0, rd, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sb_err got=%b exp=0", e); end
    do_access(1'b0, 32'h20, 32'h0, 3'd2, rd, e, lat);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL sb_lw got=%h exp=11ab3344", rd); end
    do_access(1'b0, 32'h22, 32'h0, 3'd0, rd, e, lat);
    checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb got=%h exp=ffffffab", rd); end
    do_access(1'b0, 32'h22, 32'h0, 3'd4, rd, e, lat);
    checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL lbu got=%h exp=000000ab", rd); end
    $display("byte: LBU 0x22 -> %h err=%b", rd, e);
  endtask

  task automatic test_half;
    logic [31:0] rd, exp_rd; logic e, exp_e; int lat;
    mdl_access(1'b1, 32'h30, 32'h5555AAAA, 3'd2, exp_rd, exp_e);
    do_access(1'b1, 32'h30, 32'h5555AAAA, 3'd2, rd, e, lat);
    mdl_access(1'b1, 32'h32, 32'h00008001, 3'd1, exp_rd, exp_e);
    do_access(1'b1, 32'h32, 32'h00008001, 3'd1, rd, e, lat);
    do_access(1'b0, 32'h32, 32'h0, 3'd1, rd, e, lat);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh got=%h exp=ffff8001", rd); end
    do_access(1'b0, 32'h32, 32'h0, 3'd5, rd, e, lat);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu got=%h exp=00008001", rd); end
    do_access(1'b0, 32'h30, 32'h0, 3'd2, rd, e, lat);
    checks++; if (rd !== 32'h8001AAAA) begin errors++; $display("FAIL sh_lw got=%h exp=8001aaaa", rd); end
    $display("half: LW 0x30 -> %h err=%b", rd, e);
  endtask

  task automatic test_errors;
    logic [31:0] rd, exp_rd; logic e, exp_e; int lat;
    mdl_access(1'b1, 32'h40, 32'hCAFEF00D, 3'd2, exp_rd, exp_e);
    do_access(1'b1, 32'h40, 32'hCAFEF00D, 3'd2, rd, e, lat);
    do_access(1'b0, 32'h41, 32'h0, 3'd2, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'd0 || lat !== 2) begin errors++; $display("FAIL lw_misaligned got=%h/%b lat=%0d exp=0/1 lat=2", rd, e, lat); end
    do_access(1'b1, 32'h43, 32'h00001234, 3'd1, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sh_misaligned got=%b exp=1", e); end
    do_access(1'b0, 32'h40, 32'h0, 3'd2, rd, e, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL sh_misaligned_nowrite got=%h exp=cafef00d", rd); end
    do_access(1'b0, 32'h40, 32'h0, 3'd3, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL load_f3_011 got=%h/%b exp=0/1", rd, e); end
    do_access(1'b1, 32'h40, 32'h000000EE, 3'd4, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL store_f3_100 got=%b exp=1", e); end
    do_access(1'b0, 32'h40, 32'h0, 3'd2, rd, e, lat);
    checks++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL store_f3_100_nowrite got=%h/%b exp=cafef00d/0", rd, e); end
    $display("errors: LW 0x40 after rejected stores -> %h", rd);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd, wd, last_wd, a; logic exp_e, w;
    last_wd = 32'd0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      w  = (k % 2 == 0);
      a  = 32'h200 + 32'(4 * (k / 2));
      wd = $urandom;
      if (w) last_wd = wd;
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = wd; bus.f3 = 3'd2;
      mdl_access(w, a, wd, 3'd2, exp_rd, exp_e);
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_gap k=%0d ready=%b exp=0", k, bus.ready); end
      bus.we = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_pulse k=%0d ready=%b exp=1", k, bus.ready); end
      checks++; if (bus.rdata !== exp_rd || bus.err !== exp_e) begin errors++; $display("FAIL b2b_data k=%0d got=%h/%b exp=%h/%b", k, bus.rdata, bus.err, exp_rd, exp_e); end
      if (!w) begin
        checks++; if (bus.rdata !== last_wd) begin errors++; $display("FAIL b2b_store_echo k=%0d got=%h exp=%h", k, bus.rdata, last_wd); end
      end
      $display("b2b k=%0d we=%b addr=%h rdata=%h ready=%b", k, w, a, bus.rdata, bus.ready);
    end
    bus.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, exp_rd; logic e, exp_e; int lat;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.f3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b0 || bus.rdata !== 32'd0) begin errors++; $display("FAIL rst_in_access got=%b/%h exp=0/0", bus.ready, bus.rdata); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_no_late_pulse got=%b exp=0", bus.ready); end
    do_access(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    checks++; if (lat !== 2 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_then_idle got=%h lat=%0d exp=deadbeef lat=2", rd, lat); end
    // Store accepted, then reset in its ACCESS cycle.
    mdl_access(1'b1, 32'h50, 32'h0BADC0DE, 3'd2, exp_rd, exp_e);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h50; bus.wdata = 32'h0BADC0DE; bus.f3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_access(1'b0, 32'h50, 32'h0, 3'd2, rd, e, lat);
    checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL store_survives_rst got=%h exp=0badc0de", rd); end
    do_access(1'b0, 32'h10 + 32'(MEM_BYTES), 32'h0, 3'd2, rd, e, lat);
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL alias got=%h/%b exp=deadbeef/0", rd, e); end
    $display("reset_mid: alias LW -> %h", rd);
  endtask

  task automatic test_random;
    logic [31:0] rd, exp_rd, a, d; logic e, exp_e, w; logic [2:0] f; int lat;
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(4 * i);
      d = $urandom;
      mdl_access(1'b1, a, d, 3'd2, exp_rd, exp_e);
      do_access(1'b1, a, d, 3'd2, rd, e, lat);
    end
    for (int i = 0; i < 150; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 63));
      a = a | ({$urandom} << 10);
      d = $urandom;
      w = 1'($urandom);
      f = 3'($urandom);
      mdl_access(w, a, d, f, exp_rd, exp_e);
      do_access(w, a, d, f, rd, e, lat);
      checks++;
      if (lat !== 2 || rd !== exp_rd || e !== exp_e) begin
        errors++;
        $display("FAIL random i=%0d we=%b f3=%0d addr=%h got=%h/%b lat=%0d exp=%h/%b lat=2", i, w, f, a, rd, e, lat, exp_rd, exp_e);
      end
      $display("rand i=%0d we=%b f3=%0d addr=%h rdata=%h err=%b", i, w, f, a, rd, e);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0; bus.f3 = 3'd0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
